cpu6_dmem_responder: RTL

// - Data-memory responder at the far end of the cpu6 MEM-stage load/store port.
// - Accepts one load or store at a time over a valid/ready request channel.
// - For stores: builds byte strobes and lane-replicated write data from the access width and addr[1:0].
// - For loads: returns the addressed word right-aligned, raw (not sign-extended); the core's load-width mux extends it.
// - Models a word-organised SRAM with a programmable number of wait states.

---
 rtl/cpu6_dmem_responder_if.sv | 33 +++
 rtl/cpu6_dmem_responder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/cpu6_dmem_responder_if.sv
// Load/store request and response bundle between the cpu6 MEM stage (master)
// and the data-memory responder (slave).
`ifndef CPU6_XLEN
`define CPU6_XLEN 32
`endif
`ifndef CPU6_LSWIDTH_SIZE
`define CPU6_LSWIDTH_SIZE 2
`define CPU6_LSWIDTH_B 2'd0
`define CPU6_LSWIDTH_H 2'd1
`define CPU6_LSWIDTH_W 2'd2
`endif

interface cpu6_dmem_responder_if;
    logic                          req_valid;
    logic                          req_ready;
    logic                          req_write;
    logic [`CPU6_XLEN-1:0]         req_addr;
    logic [`CPU6_XLEN-1:0]         req_wdata;
    logic [`CPU6_LSWIDTH_SIZE-1:0] req_lswidth;
    logic                          rsp_valid;
    logic [`CPU6_XLEN-1:0]         rsp_rdata;
    logic                          rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_lswidth,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_lswidth,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/cpu6_dmem_responder.sv
// cpu6 data-memory responder: word-organised SRAM model behind a valid/ready
// load/store port, with programmable wait states.
// Optional feature macro: CPU6_DMEM_MISALIGN_CHK_EN (flags misaligned H/W
// accesses as errors; when undefined, H/W accesses use the aligned unit).
`ifndef CPU6_XLEN
`define CPU6_XLEN 32
`endif
`ifndef CPU6_LSWIDTH_SIZE
`define CPU6_LSWIDTH_SIZE 2
`define CPU6_LSWIDTH_B 2'd0
`define CPU6_LSWIDTH_H 2'd1
`define CPU6_LSWIDTH_W 2'd2
`endif

module cpu6_dmem_responder #(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_2000,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    cpu6_dmem_responder_if.slave bus
);
    localparam int unsigned XLEN   = `CPU6_XLEN;
    localparam int unsigned LSW_W  = `CPU6_LSWIDTH_SIZE;
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = 4;
    localparam logic [XLEN-1:0] SPAN = XLEN'(4 * DEPTH);
    localparam logic        NO_WAIT = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;

    state_e              state_q;
    logic                ready_q;
    logic                rsp_valid_q;
    logic                rsp_err_q;
    logic [XLEN-1:0]     rsp_rdata_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                write_q;
    logic [XLEN-1:0]     addr_q;
    logic [XLEN-1:0]     wdata_q;
    logic [LSW_W-1:0]    lsw_q;
    logic [31:0]         mem_q [DEPTH];

    logic                acc_write;
    logic [XLEN-1:0]     acc_addr;
    logic [XLEN-1:0]     acc_wdata;
    logic [LSW_W-1:0]    acc_lsw;
    logic [XLEN-1:0]     offset;
    logic                in_range;
    logic                misalign;
    logic                access_ok;
    logic [IDX_W-1:0]    idx;
    logic [3:0]          strb;
    logic [31:0]         lanes;
    logic [31:0]         word;
    logic [31:0]         ld_data;
    logic                handshake;
    logic                enter_resp;
    logic                mem_we;
    logic [XLEN-1:0]     rsp_rdata_d;
    logic                rsp_err_d;

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    // Live request in IDLE (zero-wait path), latched request otherwise.
    always_comb begin
        acc_write = write_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_lsw   = lsw_q;
        if (state_q == S_IDLE) begin
            acc_write = bus.req_write;
            acc_addr  = bus.req_addr;
            acc_wdata = bus.req_wdata;
            acc_lsw   = bus.req_lswidth;
        end
    end

    // Address decode, range and alignment checks.
    always_comb begin
        offset   = acc_addr - ADDR_BASE;
        in_range = (acc_addr >= ADDR_BASE) && (offset < SPAN);
        idx      = offset[IDX_W+1:2];
`ifdef CPU6_DMEM_MISALIGN_CHK_EN
        misalign = ((acc_lsw == `CPU6_LSWIDTH_H) && acc_addr[0]) ||
                   ((acc_lsw == `CPU6_LSWIDTH_W) && (acc_addr[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
        access_ok = in_range && !misalign;
    end

    assign word = mem_q[idx];

    // Byte strobes, replicated write lanes and right-aligned load data.
    always_comb begin
        strb    = 4'b1111;
        lanes   = acc_wdata[31:0];
        ld_data = word;
        case (acc_lsw)
            `CPU6_LSWIDTH_B: begin
                strb    = 4'b0001 << acc_addr[1:0];
                lanes   = {4{acc_wdata[7:0]}};
                ld_data = word >> {acc_addr[1:0], 3'b000};
            end
            `CPU6_LSWIDTH_H: begin
                strb    = 4'b0011 << {acc_addr[1], 1'b0};
                lanes   = {2{acc_wdata[15:0]}};
                ld_data = word >> {acc_addr[1], 4'b0000};
            end
            default: ;
        endcase
    end

    assign handshake   = bus.req_valid && ready_q;
    assign enter_resp  = ((state_q == S_IDLE) && handshake && NO_WAIT) ||
                         ((state_q == S_ACCESS) && (cnt_q == '0));
    assign mem_we      = enter_resp && acc_write && access_ok && !reset;
    assign rsp_rdata_d = (access_ok && !acc_write) ? XLEN'(ld_data) : '0;
    assign rsp_err_d   = !access_ok;

    // Store commit on the edge that enters RESP; only strobed bytes change.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) begin
                    mem_q[idx][8*b +: 8] <= lanes[8*b +: 8];
                end
            end
        end
    end

    // Request FSM IDLE -> ACCESS -> RESP with registered handshake/response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (handshake) begin
                        write_q <= bus.req_write;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        lsw_q   <= bus.req_lswidth;
                        ready_q <= 1'b0;
                        if (NO_WAIT) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= rsp_rdata_d;
                            rsp_err_q   <= rsp_err_d;
                        end else begin
                            state_q <= S_ACCESS;
                            cnt_q   <= CNT_W'(WAIT_CYCLES - 1);
                        end
                    end
                end
                S_ACCESS: begin
                    if (cnt_q == '0) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rsp_rdata_d;
                        rsp_err_q   <= rsp_err_d;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end
endmodule
